// File: rtl/crg_job_scheduler.sv
// Round-robin job scheduler sharing one CRG between N_REQ requesters.
// Accepts a job, validates it, pulses run, then tags and counts CRG beats.
module crg_job_scheduler #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [N_REQ-1:0]         req_vld_i,
    output logic [N_REQ-1:0]         req_rdy_o,
    input  logic [N_REQ*3-1:0]       req_width_i,
    input  logic [N_REQ*3-1:0]       req_mode_i,
    input  logic [N_REQ*CNT_W-1:0]   req_cnt_start_i,
    input  logic [N_REQ*CNT_W-1:0]   req_cnt_end_i,
    output logic [2:0]               crg_width_o,
    output logic [2:0]               crg_mode_o,
    output logic [CNT_W-1:0]         crg_cnt_start_o,
    output logic [CNT_W-1:0]         crg_cnt_end_o,
    output logic                     crg_run_o,
    input  logic                     crg_dvld_i,
    output logic                     beat_vld_o,
    output logic [$clog2(N_REQ)-1:0] beat_id_o,
    output logic                     beat_last_o,
    output logic [N_REQ-1:0]         done_o,
    output logic [N_REQ-1:0]         err_o,
    output logic                     busy_o
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_RUN,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    logic [ID_W:0]    arb_idx;
    logic             accept;
    logic [ID_W-1:0]  job_id;
    logic [2:0]       job_width;
    logic [2:0]       job_mode;
    logic [CNT_W-1:0] job_start;
    logic [CNT_W-1:0] job_end;
    logic [CNT_W:0]   job_len;
    logic [CNT_W:0]   beat_cnt;
    logic [TMR_W-1:0] idle_tmr;
    logic             width_ok;
    logic             mode_ok;
    logic             job_ok;
    logic             beat;
    logic             last_beat;
    logic             tmo;

    // Search starts one past the previous winner so priority rotates
    always_comb begin
        grant     = last_grant;
        grant_vld = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            arb_idx = {1'b0, last_grant} + (ID_W+1)'(i);
            if (arb_idx >= (ID_W+1)'(N_REQ))
                arb_idx = arb_idx - (ID_W+1)'(N_REQ);
            if (!grant_vld && req_vld_i[arb_idx[ID_W-1:0]]) begin
                grant     = arb_idx[ID_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_vld;

    always_comb begin
        width_ok = 1'b0;
        case (job_width)
            3'b000, 3'b001, 3'b011, 3'b111: width_ok = 1'b1;
            default: width_ok = 1'b0;
        endcase
        mode_ok = 1'b0;
        case (job_mode)
            3'b100, 3'b001, 3'b010: mode_ok = 1'b1;
            default: mode_ok = 1'b0;
        endcase
    end

    assign job_ok = width_ok && mode_ok
                 && (job_mode != 3'b001 || job_width[2:1] == 2'b00)
                 && (job_end >= job_start);

    // One extra bit so the full counter range fits
    assign job_len   = {1'b0, job_end} - {1'b0, job_start}
                     + (CNT_W+1)'(1);
    assign beat      = (state == S_WAIT) && crg_dvld_i;
    assign last_beat = beat && (beat_cnt == job_len - (CNT_W+1)'(1));
    assign tmo       = (state == S_WAIT) && !crg_dvld_i
                    && (idle_tmr == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_vld) state_nxt = S_CHECK;
            S_CHECK: state_nxt = job_ok ? S_SETUP : S_ERR;
            S_SETUP: state_nxt = S_RUN;
            S_RUN:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (last_beat) state_nxt = S_DONE;
                else if (tmo)  state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant <= ID_W'(N_REQ - 1);
            job_id     <= '0;
            job_width  <= '0;
            job_mode   <= '0;
            job_start  <= '0;
            job_end    <= '0;
            beat_cnt   <= '0;
            idle_tmr   <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                job_id     <= grant;
                job_width  <= req_width_i[grant*3 +: 3];
                job_mode   <= req_mode_i[grant*3 +: 3];
                job_start  <= req_cnt_start_i[grant*CNT_W +: CNT_W];
                job_end    <= req_cnt_end_i[grant*CNT_W +: CNT_W];
            end
            if (state == S_RUN) begin
                beat_cnt <= '0;
                idle_tmr <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + (CNT_W+1)'(1);
                idle_tmr <= '0;
            end else if (state == S_WAIT) begin
                idle_tmr <= idle_tmr + TMR_W'(1);
            end
        end
    end

    always_comb begin
        req_rdy_o = '0;
        if (accept) req_rdy_o[grant] = 1'b1;
        done_o = '0;
        if (state == S_DONE) done_o[job_id] = 1'b1;
        err_o = '0;
        if (state == S_ERR) err_o[job_id] = 1'b1;
        crg_run_o       = (state == S_RUN);
        busy_o          = (state != S_IDLE);
        beat_vld_o      = beat;
        beat_last_o     = last_beat;
        beat_id_o       = job_id;
        crg_width_o     = job_width;
        crg_mode_o      = job_mode;
        crg_cnt_start_o = job_start;
        crg_cnt_end_o   = job_end;
    end

endmodule

// File: tb/tb_crg_job_scheduler.sv
// Directed bench for crg_job_scheduler: arbitration, checks,
// beat tagging, timeout, reset abort and stray dvld handling.
module tb_crg_job_scheduler;
    localparam int N_REQ   = 4;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic [N_REQ-1:0]       req_vld_i;
    logic [N_REQ-1:0]       req_rdy_o;
    logic [N_REQ*3-1:0]     req_width_i;
    logic [N_REQ*3-1:0]     req_mode_i;
    logic [N_REQ*CNT_W-1:0] req_cnt_start_i;
    logic [N_REQ*CNT_W-1:0] req_cnt_end_i;
    logic [2:0]             crg_width_o;
    logic [2:0]             crg_mode_o;
    logic [CNT_W-1:0]       crg_cnt_start_o;
    logic [CNT_W-1:0]       crg_cnt_end_o;
    logic                   crg_run_o;
    logic                   crg_dvld_i;
    logic                   beat_vld_o;
    logic [1:0]             beat_id_o;
    logic                   beat_last_o;
    logic [N_REQ-1:0]       done_o;
    logic [N_REQ-1:0]       err_o;
    logic                   busy_o;

    int total = 0;
    int bad   = 0;

    crg_job_scheduler #(
        .N_REQ(N_REQ),
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .req_vld_i(req_vld_i),
        .req_rdy_o(req_rdy_o),
        .req_width_i(req_width_i),
        .req_mode_i(req_mode_i),
        .req_cnt_start_i(req_cnt_start_i),
        .req_cnt_end_i(req_cnt_end_i),
        .crg_width_o(crg_width_o),
        .crg_mode_o(crg_mode_o),
        .crg_cnt_start_o(crg_cnt_start_o),
        .crg_cnt_end_o(crg_cnt_end_o),
        .crg_run_o(crg_run_o),
        .crg_dvld_i(crg_dvld_i),
        .beat_vld_o(beat_vld_o),
        .beat_id_o(beat_id_o),
        .beat_last_o(beat_last_o),
        .done_o(done_o),
        .err_o(err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int k, input logic [2:0] w,
                           input logic [2:0] m,
                           input logic [CNT_W-1:0] s,
                           input logic [CNT_W-1:0] e);
        req_width_i[k*3 +: 3]             = w;
        req_mode_i[k*3 +: 3]              = m;
        req_cnt_start_i[k*CNT_W +: CNT_W] = s;
        req_cnt_end_i[k*CNT_W +: CNT_W]   = e;
    endtask

    task automatic do_reset();
        rst_n_i         = 1'b0;
        req_vld_i       = '0;
        req_width_i     = '0;
        req_mode_i      = '0;
        req_cnt_start_i = '0;
        req_cnt_end_i   = '0;
        crg_dvld_i      = 1'b0;
        tick();
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({busy_o, crg_run_o, beat_vld_o, done_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_ctl got busy=%b run=%b bv=%b done=%b err=%b want 0",
                     busy_o, crg_run_o, beat_vld_o, done_o, err_o);
        end
        total++;
        if ({crg_width_o, crg_mode_o, crg_cnt_start_o,
             crg_cnt_end_o, beat_id_o} !== '0) begin
            bad++;
            $display("FAIL reset_cfg got w=%b m=%b s=%h e=%h id=%0d want 0",
                     crg_width_o, crg_mode_o, crg_cnt_start_o,
                     crg_cnt_end_o, beat_id_o);
        end
        rst_n_i = 1'b1;
    endtask

    task automatic test_single_job();
        do_reset();
        set_req(0, 3'b000, 3'b100, 32'd3, 32'h13);
        req_vld_i = 4'b0001;
        #1;
        total++;
        if (req_rdy_o !== 4'b0001) begin
            bad++;
            $display("FAIL single_rdy got %b want 0001", req_rdy_o);
        end
        tick();
        req_vld_i = '0;
        total++;
        if (crg_cnt_start_o !== 32'd3 || crg_cnt_end_o !== 32'h13
            || crg_mode_o !== 3'b100 || !busy_o) begin
            bad++;
            $display("FAIL single_cfg got s=%h e=%h m=%b busy=%b want 3 13 100 1",
                     crg_cnt_start_o, crg_cnt_end_o, crg_mode_o, busy_o);
        end
        tick();
        total++;
        if (crg_run_o !== 1'b0) begin
            bad++;
            $display("FAIL single_run_early got %b want 0", crg_run_o);
        end
        tick();
        total++;
        if (crg_run_o !== 1'b1) begin
            bad++;
            $display("FAIL single_run got %b want 1", crg_run_o);
        end
        tick();
        for (int b = 0; b < 17; b++) begin
            crg_dvld_i = 1'b1;
            #1;
            total++;
            if (beat_vld_o !== 1'b1 || beat_id_o !== 2'd0
                || beat_last_o !== (b == 16)) begin
                bad++;
                $display("FAIL single_beat%0d got v=%b id=%0d last=%b want 1 0 %b",
                         b, beat_vld_o, beat_id_o, beat_last_o, b == 16);
            end
            tick();
        end
        crg_dvld_i = 1'b0;
        total++;
        if (done_o !== 4'b0001 || err_o !== 4'b0000) begin
            bad++;
            $display("FAIL single_done got done=%b err=%b want 0001 0000",
                     done_o, err_o);
        end
        tick();
        total++;
        if (busy_o !== 1'b0 || done_o !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle got busy=%b done=%b want 0 0000",
                     busy_o, done_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [N_REQ-1:0] exp_rdy [5];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < N_REQ; k++)
            set_req(k, 3'b000, 3'b100, 32'd0, 32'd0);
        req_vld_i = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            total++;
            if (req_rdy_o !== exp_rdy[j]) begin
                bad++;
                $display("FAIL b2b_grant%0d got %b want %b",
                         j, req_rdy_o, exp_rdy[j]);
            end
            tick();
            tick();
            tick();
            total++;
            if (crg_run_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_run%0d got %b want 1", j, crg_run_o);
            end
            tick();
            crg_dvld_i = 1'b1;
            #1;
            total++;
            if (beat_vld_o !== 1'b1 || beat_last_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b last=%b want 1 1",
                         j, beat_vld_o, beat_last_o);
            end
            tick();
            crg_dvld_i = 1'b0;
            total++;
            if (done_o !== exp_rdy[j]) begin
                bad++;
                $display("FAIL b2b_done%0d got %b want %b",
                         j, done_o, exp_rdy[j]);
            end
            tick();
        end
        req_vld_i = '0;
    endtask

    task automatic run_bad_job(input string nm, input logic [2:0] w,
                               input logic [2:0] m,
                               input logic [CNT_W-1:0] s,
                               input logic [CNT_W-1:0] e);
        logic saw_run;
        saw_run = 1'b0;
        set_req(2, w, m, s, e);
        req_vld_i = 4'b0100;
        #1;
        total++;
        if (req_rdy_o !== 4'b0100) begin
            bad++;
            $display("FAIL %s_rdy got %b want 0100", nm, req_rdy_o);
        end
        tick();
        req_vld_i = '0;
        saw_run |= crg_run_o;
        tick();
        saw_run |= crg_run_o;
        total++;
        if (err_o !== 4'b0100 || done_o !== 4'b0000) begin
            bad++;
            $display("FAIL %s_err got err=%b done=%b want 0100 0000",
                     nm, err_o, done_o);
        end
        tick();
        saw_run |= crg_run_o;
        total++;
        if (saw_run !== 1'b0 || err_o !== 4'b0000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_after got run=%b err=%b busy=%b want 0 0000 0",
                     nm, saw_run, err_o, busy_o);
        end
    endtask

    task automatic test_reject();
        do_reset();
        run_bad_job("rej_mode", 3'b011, 3'b001, 32'd0, 32'd0);
        run_bad_job("rej_range", 3'b000, 3'b100, 32'd5, 32'd4);
    endtask

    task automatic test_timeout();
        int  n;
        logic hit;
        logic saw_done;
        do_reset();
        set_req(1, 3'b000, 3'b100, 32'd0, 32'd9);
        req_vld_i = 4'b0010;
        tick();
        req_vld_i = '0;
        tick();
        tick();
        tick();
        for (int b = 0; b < 3; b++) begin
            crg_dvld_i = 1'b1;
            tick();
        end
        crg_dvld_i = 1'b0;
        n = 0;
        hit = 1'b0;
        saw_done = 1'b0;
        while (n < TIMEOUT + 8 && !hit) begin
            saw_done |= (done_o != 0);
            if (err_o != 0) hit = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        total++;
        if (!hit || n != TIMEOUT || err_o !== 4'b0010) begin
            bad++;
            $display("FAIL timeout_err got hit=%b n=%0d err=%b want 1 %0d 0010",
                     hit, n, err_o, TIMEOUT);
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_done got %b want 0", saw_done);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        do_reset();
        set_req(0, 3'b001, 3'b010, 32'd1, 32'd10);
        req_vld_i = 4'b0001;
        tick();
        req_vld_i = '0;
        tick();
        tick();
        tick();
        for (int b = 0; b < 5; b++) begin
            crg_dvld_i = 1'b1;
            tick();
        end
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({busy_o, beat_vld_o, beat_last_o, done_o, err_o,
             crg_width_o, crg_mode_o, crg_cnt_end_o} !== '0) begin
            bad++;
            $display("FAIL abort_zero got busy=%b bv=%b done=%b err=%b w=%b m=%b e=%h",
                     busy_o, beat_vld_o, done_o, err_o,
                     crg_width_o, crg_mode_o, crg_cnt_end_o);
        end
        crg_dvld_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        set_req(3, 3'b000, 3'b100, 32'd0, 32'd0);
        req_vld_i = 4'b1001;
        #1;
        total++;
        if (req_rdy_o !== 4'b0001) begin
            bad++;
            $display("FAIL abort_grant got %b want 0001", req_rdy_o);
        end
        req_vld_i = '0;
    endtask

    task automatic test_stray_dvld();
        do_reset();
        crg_dvld_i = 1'b1;
        #1;
        total++;
        if (beat_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_idle got bv=%b busy=%b want 0 0",
                     beat_vld_o, busy_o);
        end
        set_req(3, 3'b111, 3'b010, 32'd7, 32'd9);
        req_vld_i = 4'b1000;
        tick();
        req_vld_i = '0;
        tick();
        total++;
        if (beat_vld_o !== 1'b0 || crg_run_o !== 1'b0) begin
            bad++;
            $display("FAIL stray_setup got bv=%b run=%b want 0 0",
                     beat_vld_o, crg_run_o);
        end
        crg_dvld_i = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 3; b++) begin
            crg_dvld_i = 1'b1;
            #1;
            total++;
            if (beat_vld_o !== 1'b1 || beat_id_o !== 2'd3
                || beat_last_o !== (b == 2)) begin
                bad++;
                $display("FAIL stray_beat%0d got v=%b id=%0d last=%b want 1 3 %b",
                         b, beat_vld_o, beat_id_o, beat_last_o, b == 2);
            end
            tick();
        end
        crg_dvld_i = 1'b0;
        total++;
        if (done_o !== 4'b1000) begin
            bad++;
            $display("FAIL stray_done got %b want 1000", done_o);
        end
        tick();
    endtask

    initial begin
        rst_n_i         = 1'b0;
        req_vld_i       = '0;
        req_width_i     = '0;
        req_mode_i      = '0;
        req_cnt_start_i = '0;
        req_cnt_end_i   = '0;
        crg_dvld_i      = 1'b0;
        test_reset();
        test_single_job();
        test_back_to_back();
        test_reject();
        test_timeout();
        test_reset_abort();
        test_stray_dvld();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crg_job_scheduler.md
Name: crg_job_scheduler

Overview:
- Shares one CRG instance between N_REQ requesters; round-robin arbitration.
- Per job: latches width/mode/counter range, programs CRG, pulses run, counts returned dvld beats, tags each beat with requester id, signals done or error.
- Sits between requester front-ends and CRG. CRG key_i and party_i are tied at top level and not scheduled here.

Parameters:
N_REQ, 4, number of requesters (2..8)
CNT_W, 32, width of the CRG counter range fields
TIMEOUT, 64, max cycles with no dvld beat while waiting (must exceed CRG pipeline latency, 27)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
req_vld_i  in  N_REQ  job request valid, one bit per requester
req_rdy_o  out  N_REQ  job accepted; one-hot, combinational, asserted only in IDLE
req_width_i  in  N_REQ*3  per-requester width code; slice k = [k*3 +: 3]
req_mode_i  in  N_REQ*3  per-requester mode code
req_cnt_start_i  in  N_REQ*CNT_W  first counter value, inclusive
req_cnt_end_i  in  N_REQ*CNT_W  last counter value, inclusive
crg_width_o  out  3  to CRG width_i
crg_mode_o  out  3  to CRG mode_i
crg_cnt_start_o  out  CNT_W  to CRG cnt_start_i
crg_cnt_end_o  out  CNT_W  to CRG cnt_end_i
crg_run_o  out  1  one-cycle run pulse to CRG
crg_dvld_i  in  1  CRG dvld_o
beat_vld_o  out  1  CRG output beat belongs to active job
beat_id_o  out  $clog2(N_REQ)  requester id of active job
beat_last_o  out  1  final beat of job
done_o  out  N_REQ  one-cycle pulse, job completed
err_o  out  N_REQ  one-cycle pulse, job rejected or timed out
busy_o  out  1  state != IDLE

Behaviour:
- Reset values: all registered outputs 0; crg_* config 0; last-grant pointer = N_REQ-1, so requester 0 wins first; beat counter 0; state IDLE.
- States: IDLE, CHECK, SETUP, RUN, WAIT, DONE, ERR.
- IDLE:
  - Winner g is the first requester with req_vld_i set, searching from last_grant+1 with wrap.
  - req_rdy_o[g]=1 in the same cycle; transfer occurs.
  - Latch fields into job registers (drive crg_*_o) and g into beat_id_o; update last_grant=g. Go to CHECK.
- CHECK: job is invalid if any of the following holds; invalid goes to ERR, valid goes to SETUP:
  - width not in {000,001,011,111};
  - mode not in {100,001,010};
  - mode 001 with width not in {000,001};
  - cnt_end < cnt_start (unsigned).
- SETUP: crg_*_o stable for one cycle. Go to RUN.
- RUN: crg_run_o=1 for exactly one cycle. Clear beat counter and idle timer. Go to WAIT.
- WAIT:
  - beat_vld_o = crg_dvld_i (combinational, WAIT only).
  - len = cnt_end - cnt_start + 1, computed CNT_W+1 wide so the full range does not overflow.
  - beat_last_o = beat_vld_o && (count == len-1).
  - On the last beat, go to DONE.
  - Idle timer resets on each beat. When it reaches TIMEOUT, go to ERR.
- DONE: done_o[id]=1 for one cycle. Go to IDLE.
- ERR: err_o[id]=1 for one cycle. Go to IDLE. last_grant stays updated, so an erroring requester does not retain priority.
- crg_dvld_i outside WAIT is ignored (no beat_vld_o, no counting).
- crg_*_o hold their values from accept until the next accept.
- A requester may hold req_vld_i high continuously; it is re-arbitrated only after return to IDLE.
- Minimum job gap: IDLE→CHECK→SETUP→RUN→WAIT; run pulse asserts 3 cycles after the accept edge.
- Reset asserted in any state returns everything to reset values immediately. No done_o or err_o is emitted for an aborted job.

Test Plan:
- Req0 only, width 000, mode 100, start 3, end 0x13 → req_rdy_o=0001; run 3 cycles later; CRG returns 17 beats tagged id 0; beat_last_o on 17th; done_o=0001 next cycle; busy_o falls.
- req_vld_i=1111 held across 5 jobs (each start=end=0) → grant order 0,1,2,3,0; each job exactly 1 beat with beat_last_o=1.
- Req2 with mode 001, width 011 → err_o=0100 two cycles after accept; crg_run_o never asserts. Repeat with start 5, end 4 → same err.
- Req1 valid job, CRG model drops dvld after 3 of 10 beats → err_o=0010 exactly TIMEOUT cycles after the 3rd beat; no done_o.
- rst_n_i low during WAIT after 5 beats → outputs zero at once; after release, req0 and req3 pending → req0 granted first.
- Stray crg_dvld_i pulses in IDLE and SETUP → beat_vld_o stays 0; beat counter of next job starts at 0.
